// File: rtl/direction_sequencer.sv
// Snake heading sequencer: decodes PS/2 arrow and pause keys, queues legal turns,
// and releases one turn per game tick.
module direction_sequencer #(
    parameter int QDEPTH = 2
) (
    input  logic       VGA_clk,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    input  logic       game_tick,
    input  logic       game_over,
    output logic [2:0] direction,
    output logic       dir_valid,
    output logic       paused,
    output logic [1:0] queue_level
);

    localparam logic [2:0] DIR_STOP = 3'b000;
    localparam logic [2:0] DIR_UP   = 3'b001;
    localparam logic [2:0] DIR_LEFT = 3'b010;
    localparam logic [2:0] DIR_DOWN = 3'b011;
    localparam logic [2:0] DIR_RGHT = 3'b100;
    localparam logic [2:0] DIR_OVER = 3'b111;
    localparam logic [1:0] LAST     = 2'(QDEPTH - 1);
    localparam logic [1:0] FULL     = 2'(QDEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} pstate_t;

    pstate_t    state, state_nxt;
    logic       make_vld, make_ext;
    logic [2:0] mem [QDEPTH];
    logic [1:0] rd_ptr, wr_ptr, count;
    logic [2:0] turn, ref_dir;
    logic [1:0] tail_idx;
    logic       turn_ok, push, pop, pause_tgl;

    function automatic logic [2:0] key_to_dir(input logic [7:0] code);
        case (code)
            8'h75:   return DIR_UP;
            8'h6B:   return DIR_LEFT;
            8'h72:   return DIR_DOWN;
            8'h74:   return DIR_RGHT;
            default: return DIR_STOP;
        endcase
    endfunction

    function automatic logic [2:0] opposite(input logic [2:0] d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RGHT;
            DIR_RGHT: return DIR_LEFT;
            default:  return DIR_STOP;
        endcase
    endfunction

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Scan-code parser; break sequences consume their trailing byte silently
    always_comb begin
        state_nxt = state;
        make_vld  = 1'b0;
        make_ext  = 1'b0;
        if (ps2_key_pressed) begin
            case (state)
                IDLE: begin
                    if (ps2_key_data == 8'hE0)      state_nxt = EXT;
                    else if (ps2_key_data == 8'hF0) state_nxt = BRK;
                    else                            make_vld  = 1'b1;
                end
                EXT: begin
                    if (ps2_key_data == 8'hF0) state_nxt = EXT_BRK;
                    else begin
                        make_vld  = 1'b1;
                        make_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (game_over) begin
            state_nxt = IDLE;
            make_vld  = 1'b0;
        end
    end

    always_ff @(posedge VGA_clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Turns are checked against the newest pending heading so chained turns cannot reverse
    always_comb begin
        turn      = make_vld ? key_to_dir(ps2_key_data) : DIR_STOP;
        pause_tgl = make_vld && !make_ext && (ps2_key_data == 8'h4D);
        tail_idx  = (wr_ptr == 2'd0) ? LAST : wr_ptr - 2'd1;
        ref_dir   = (count != 2'd0) ? mem[tail_idx] : direction;
        turn_ok   = (turn != DIR_STOP) && !paused &&
                    ((ref_dir == DIR_STOP) ||
                     ((turn != ref_dir) && (turn != opposite(ref_dir))));
        pop       = game_tick && !paused && !game_over && (count != 2'd0);
        push      = turn_ok && !game_over && ((count != FULL) || pop);
    end

    always_ff @(posedge VGA_clk or negedge resetn) begin
        if (!resetn) begin
            direction <= DIR_STOP;
            dir_valid <= 1'b0;
            paused    <= 1'b0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            count     <= 2'd0;
            for (int i = 0; i < QDEPTH; i++) mem[i] <= DIR_STOP;
        end else if (game_over) begin
            direction <= DIR_OVER;
            dir_valid <= 1'b0;
            paused    <= 1'b0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            count     <= 2'd0;
        end else begin
            dir_valid <= pop;
            if (pop)                        direction <= mem[rd_ptr];
            else if (direction == DIR_OVER) direction <= DIR_STOP;
            if (pause_tgl) paused <= ~paused;
            if (push) begin
                mem[wr_ptr] <= turn;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign queue_level = count;

endmodule

// File: tb/tb_direction_sequencer.sv
// Directed bench: expected headings queued at each tick, a monitor checks every dir_valid pulse.
module tb_direction_sequencer;

    logic       VGA_clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic       game_tick = 1'b0;
    logic       game_over = 1'b0;
    logic [2:0] direction;
    logic       dir_valid;
    logic       paused;
    logic [1:0] queue_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] sb [$];

    direction_sequencer #(.QDEPTH(2)) dut (
        .VGA_clk(VGA_clk), .resetn(resetn), .ps2_key_data(ps2_key_data),
        .ps2_key_pressed(ps2_key_pressed), .game_tick(game_tick), .game_over(game_over),
        .direction(direction), .dir_valid(dir_valid), .paused(paused),
        .queue_level(queue_level)
    );

    always #5 VGA_clk = ~VGA_clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge VGA_clk) begin
        if (resetn && dir_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL dir_valid: unexpected pulse, direction %0d", direction);
            end else begin
                logic [2:0] e;
                e = sb.pop_front();
                if (direction !== e) begin
                    n_bad++;
                    $display("FAIL pop_dir: got %0d expected %0d", direction, e);
                end
            end
        end
    end

    task automatic key(input logic [7:0] b);
        @(posedge VGA_clk); #1;
        ps2_key_data = b; ps2_key_pressed = 1'b1;
        @(posedge VGA_clk); #1;
        ps2_key_pressed = 1'b0;
    endtask

    task automatic tick(input logic [2:0] exp_dir, input bit exp_pop);
        @(posedge VGA_clk); #1;
        if (exp_pop) sb.push_back(exp_dir);
        game_tick = 1'b1;
        @(posedge VGA_clk); #1;
        game_tick = 1'b0;
    endtask

    task automatic key_tick(input logic [7:0] b, input logic [2:0] exp_dir);
        @(posedge VGA_clk); #1;
        sb.push_back(exp_dir);
        ps2_key_data = b; ps2_key_pressed = 1'b1; game_tick = 1'b1;
        @(posedge VGA_clk); #1;
        ps2_key_pressed = 1'b0; game_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge VGA_clk);
        #1;
        chk("rst_dir", int'(direction), 0);
        chk("rst_valid", int'(dir_valid), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_level", int'(queue_level), 0);
        resetn = 1'b1;

        // extended up, then one tick
        key(8'hE0); key(8'h75);
        chk("ext_up_level", int'(queue_level), 1);
        tick(3'd1, 1'b1);
        chk("ext_up_dir", int'(direction), 1);
        chk("ext_up_drain", int'(queue_level), 0);
        @(posedge VGA_clk); #1;
        chk("valid_one_cycle", int'(dir_valid), 0);

        // reversal rejection against direction, then against tail
        key(8'h72);
        chk("rev_dir_level", int'(queue_level), 0);
        key(8'h6B); key(8'h74);
        chk("rev_tail_level", int'(queue_level), 1);
        tick(3'd2, 1'b1);
        key(8'h75);
        tick(3'd1, 1'b1);
        chk("back_up_dir", int'(direction), 1);

        // fill queue, third turn dropped
        key(8'h6B); key(8'h72); key(8'h74);
        chk("full_level", int'(queue_level), 2);
        tick(3'd2, 1'b1);
        chk("full_pop1", int'(direction), 2);
        tick(3'd3, 1'b1);
        chk("full_pop2", int'(direction), 3);
        chk("full_drain", int'(queue_level), 0);

        // extended break discarded, parser realigned
        key(8'hE0); key(8'hF0); key(8'h75);
        chk("brk_level", int'(queue_level), 0);
        key(8'h6B);
        chk("brk_realign", int'(queue_level), 1);

        // pause
        key(8'h4D);
        chk("pause_on", int'(paused), 1);
        tick(3'd0, 1'b0);
        chk("pause_hold_dir", int'(direction), 3);
        chk("pause_hold_level", int'(queue_level), 1);
        key(8'h74);
        chk("pause_arrow_ign", int'(queue_level), 1);
        key(8'h4D);
        chk("pause_off", int'(paused), 0);
        tick(3'd2, 1'b1);
        chk("unpause_pop", int'(direction), 2);

        // game over flush
        key(8'h75); key(8'h6B);
        chk("go_pre_level", int'(queue_level), 2);
        @(posedge VGA_clk); #1;
        game_over = 1'b1;
        @(posedge VGA_clk); #1;
        chk("go_dir", int'(direction), 7);
        chk("go_level", int'(queue_level), 0);
        key(8'h72);
        tick(3'd0, 1'b0);
        chk("go_key_ign", int'(queue_level), 0);
        chk("go_paused", int'(paused), 0);
        game_over = 1'b0;
        @(posedge VGA_clk); #1;
        chk("go_release_dir", int'(direction), 0);
        key(8'h72);
        chk("go_after_key", int'(queue_level), 1);
        tick(3'd3, 1'b1);
        chk("go_after_dir", int'(direction), 3);

        // reset between prefix and code
        key(8'hE0);
        @(posedge VGA_clk); #1;
        resetn = 1'b0;
        #1;
        chk("async_rst_dir", int'(direction), 0);
        chk("async_rst_level", int'(queue_level), 0);
        @(posedge VGA_clk); @(posedge VGA_clk); #1;
        resetn = 1'b1;
        key(8'h75);
        chk("post_rst_level", int'(queue_level), 1);

        // simultaneous push/pop, including into a full queue
        key_tick(8'h6B, 3'd1);
        chk("pp_level", int'(queue_level), 1);
        chk("pp_dir", int'(direction), 1);
        key(8'h72);
        chk("pp_fill", int'(queue_level), 2);
        key_tick(8'h74, 3'd2);
        chk("pp_full_level", int'(queue_level), 2);
        tick(3'd3, 1'b1);
        tick(3'd4, 1'b1);
        chk("pp_final_dir", int'(direction), 4);
        chk("pp_final_level", int'(queue_level), 0);

        repeat (3) @(posedge VGA_clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
